// File: rtl/jtdd_gfx_rom.sv
// Graphics ROM responder: char/scroll/object fetch ports share one 16-bit SDRAM read port.
// Each client caches one word and re-fetches only when its address leaves that word.
module jtdd_gfx_rom #(
    parameter logic [21:0] CHAR_OFFSET = 22'h00000,
    parameter logic [21:0] SCR_OFFSET  = 22'h08000,
    parameter logic [21:0] OBJ_OFFSET  = 22'h28000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [14:0] char_addr,
    output logic [7:0]  char_data,
    output logic        char_ok,
    input  logic [16:0] scr_addr,
    output logic [15:0] scr_data,
    output logic        scr_ok,
    input  logic [17:0] obj_addr,
    output logic [15:0] obj_data,
    output logic        obj_ok,
    output logic [21:0] sdram_addr,
    output logic        sdram_req,
    input  logic        sdram_ack,
    input  logic        data_rdy,
    input  logic [15:0] sdram_dout
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DATA = 2'd2
    } state_t;

    localparam logic [1:0] ID_CHAR = 2'd0;
    localparam logic [1:0] ID_SCR  = 2'd1;
    localparam logic [1:0] ID_OBJ  = 2'd2;

    state_t      r_state;
    logic [1:0]  r_id;
    logic [17:0] r_cap;
    logic        r_dl_q;

    logic [15:0] r_char_word;
    logic [13:0] r_char_served;
    logic        r_char_valid;
    logic [15:0] r_scr_word;
    logic [16:0] r_scr_served;
    logic        r_scr_valid;
    logic [15:0] r_obj_word;
    logic [17:0] r_obj_served;
    logic        r_obj_valid;

    logic        w_char_hit;
    logic        w_scr_hit;
    logic        w_obj_hit;
    logic        w_any_pend;
    logic        w_wr_en;
    logic        w_dl_rise;
    logic [1:0]  w_sel_id;
    logic [17:0] w_sel_cap;
    logic [21:0] w_sel_addr;

    // Hits are combinational so ok drops in the very cycle the address moves
    assign w_char_hit = r_char_valid && (r_char_served == char_addr[14:1]) && !downloading;
    assign w_scr_hit  = r_scr_valid  && (r_scr_served  == scr_addr)        && !downloading;
    assign w_obj_hit  = r_obj_valid  && (r_obj_served  == obj_addr)        && !downloading;
    assign w_any_pend = !(w_char_hit && w_scr_hit && w_obj_hit);
    assign w_dl_rise  = downloading && !r_dl_q;

    // Coincident ack and data in WAIT_ACK is taken as ack followed by data
    assign w_wr_en = data_rdy && ((r_state == ST_WAIT_DATA) ||
                                  ((r_state == ST_WAIT_ACK) && sdram_ack));

    assign char_data = char_addr[0] ? r_char_word[15:8] : r_char_word[7:0];
    assign char_ok   = w_char_hit;
    assign scr_data  = r_scr_word;
    assign scr_ok    = w_scr_hit;
    assign obj_data  = r_obj_word;
    assign obj_ok    = w_obj_hit;

    // Fixed-priority winner selection and SDRAM address (carry out of bit 21 discarded)
    always_comb begin
        w_sel_id   = ID_CHAR;
        w_sel_cap  = 18'd0;
        w_sel_addr = 22'd0;
        if (!w_char_hit) begin
            w_sel_id   = ID_CHAR;
            w_sel_cap  = {4'd0, char_addr[14:1]};
            w_sel_addr = CHAR_OFFSET + {8'd0, char_addr[14:1]};
        end else if (!w_scr_hit) begin
            w_sel_id   = ID_SCR;
            w_sel_cap  = {1'b0, scr_addr};
            w_sel_addr = SCR_OFFSET + {5'd0, scr_addr};
        end else if (!w_obj_hit) begin
            w_sel_id   = ID_OBJ;
            w_sel_cap  = obj_addr;
            w_sel_addr = OBJ_OFFSET + {4'd0, obj_addr};
        end else begin
            w_sel_id   = ID_CHAR;
            w_sel_cap  = 18'd0;
            w_sel_addr = 22'd0;
        end
    end

    // Request sequencer; sdram_addr is only loaded from IDLE so it is stable while requesting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_id       <= ID_CHAR;
            r_cap      <= 18'd0;
            sdram_addr <= 22'd0;
            sdram_req  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_pend && !downloading) begin
                        r_id       <= w_sel_id;
                        r_cap      <= w_sel_cap;
                        sdram_addr <= w_sel_addr;
                        sdram_req  <= 1'b1;
                        r_state    <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        r_state   <= data_rdy ? ST_IDLE : ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (data_rdy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    sdram_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Slot storage; data is stored against the address captured at request time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dl_q        <= 1'b0;
            r_char_word   <= 16'd0;
            r_char_served <= 14'd0;
            r_char_valid  <= 1'b0;
            r_scr_word    <= 16'd0;
            r_scr_served  <= 17'd0;
            r_scr_valid   <= 1'b0;
            r_obj_word    <= 16'd0;
            r_obj_served  <= 18'd0;
            r_obj_valid   <= 1'b0;
        end else begin
            r_dl_q <= downloading;
            if (w_wr_en) begin
                case (r_id)
                    ID_CHAR: begin
                        r_char_word   <= sdram_dout;
                        r_char_served <= r_cap[13:0];
                        r_char_valid  <= 1'b1;
                    end
                    ID_SCR: begin
                        r_scr_word    <= sdram_dout;
                        r_scr_served  <= r_cap[16:0];
                        r_scr_valid   <= 1'b1;
                    end
                    ID_OBJ: begin
                        r_obj_word    <= sdram_dout;
                        r_obj_served  <= r_cap;
                        r_obj_valid   <= 1'b1;
                    end
                    default: begin
                        r_char_valid  <= r_char_valid;
                    end
                endcase
            end
            // A fresh ROM load invalidates everything, overriding a same-cycle write
            if (w_dl_rise) begin
                r_char_valid <= 1'b0;
                r_scr_valid  <= 1'b0;
                r_obj_valid  <= 1'b0;
            end
        end
    end

endmodule
